// File: rtl/gpio_apb_bank.sv
// APB3 GPIO bank: synchronised/debounced inputs, set/clear outputs and edge/level
// interrupts with W1C status. Zero wait states, synchronous active-high reset.
module gpio_apb_bank #(
  parameter int NUM_PINS   = 32,
  parameter int DB_SAMPLES = 4,
  parameter int PRESC_W    = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [31:0]         PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic [NUM_PINS-1:0] irq_pin,
  output logic                irq
);

  localparam int CNT_W = (DB_SAMPLES > 2) ? $clog2(DB_SAMPLES) : 1;

  localparam logic [7:0] ADDR_DATA_IN  = 8'h00;
  localparam logic [7:0] ADDR_DATA_OUT = 8'h04;
  localparam logic [7:0] ADDR_OUT_SET  = 8'h08;
  localparam logic [7:0] ADDR_OUT_CLR  = 8'h0C;
  localparam logic [7:0] ADDR_DIR      = 8'h10;
  localparam logic [7:0] ADDR_INT_EN   = 8'h14;
  localparam logic [7:0] ADDR_INT_TYPE = 8'h18;
  localparam logic [7:0] ADDR_INT_POL  = 8'h1C;
  localparam logic [7:0] ADDR_INT_BOTH = 8'h20;
  localparam logic [7:0] ADDR_INT_STAT = 8'h24;
  localparam logic [7:0] ADDR_DB_EN    = 8'h28;
  localparam logic [7:0] ADDR_DB_PRESC = 8'h2C;

  logic [NUM_PINS-1:0] data_out_r, dir_r, int_en_r, int_type_r, int_pol_r, int_both_r;
  logic [NUM_PINS-1:0] int_stat_r, db_en_r;
  logic [NUM_PINS-1:0] sync1_r, sync2_r, filt_r, prev_r, irq_pin_r;
  logic [CNT_W-1:0]    db_cnt_r [NUM_PINS];
  logic [PRESC_W-1:0]  db_presc_r, presc_cnt_r;
  logic [31:0]         prdata_r, rdata_s;
  logic                pslverr_r, irq_r, err_s;
  logic                access_s, wr_s, rd_s, tick_s, presc_wr_s;
  logic [NUM_PINS-1:0] wdata_s, w1c_s, rise_s, fall_s, edge_ev_s, level_ev_s, event_s;
  logic                unused_s;

  function automatic logic [31:0] zext_pins(input logic [NUM_PINS-1:0] v);
    logic [31:0] r;
    r = 32'h0;
    r[NUM_PINS-1:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] zext_presc(input logic [PRESC_W-1:0] v);
    logic [31:0] r;
    r = 32'h0;
    r[PRESC_W-1:0] = v;
    return r;
  endfunction

  assign access_s   = PSEL & PENABLE;
  assign wr_s       = access_s & PWRITE;
  assign rd_s       = access_s & ~PWRITE;
  assign wdata_s    = PWDATA[NUM_PINS-1:0];
  assign presc_wr_s = wr_s && (PADDR[7:0] == ADDR_DB_PRESC);
  assign tick_s     = (presc_cnt_r == db_presc_r);
  assign unused_s   = ^{PADDR[31:8], PWDATA};

  // Read mux and error decode; DATA_IN is read-only, unmapped offsets error
  always_comb begin
    rdata_s = 32'h0;
    err_s   = 1'b0;
    case (PADDR[7:0])
      ADDR_DATA_IN:  begin rdata_s = zext_pins(filt_r); err_s = PWRITE; end
      ADDR_DATA_OUT: rdata_s = zext_pins(data_out_r);
      ADDR_OUT_SET:  rdata_s = 32'h0;
      ADDR_OUT_CLR:  rdata_s = 32'h0;
      ADDR_DIR:      rdata_s = zext_pins(dir_r);
      ADDR_INT_EN:   rdata_s = zext_pins(int_en_r);
      ADDR_INT_TYPE: rdata_s = zext_pins(int_type_r);
      ADDR_INT_POL:  rdata_s = zext_pins(int_pol_r);
      ADDR_INT_BOTH: rdata_s = zext_pins(int_both_r);
      ADDR_INT_STAT: rdata_s = zext_pins(int_stat_r);
      ADDR_DB_EN:    rdata_s = zext_pins(db_en_r);
      ADDR_DB_PRESC: rdata_s = zext_presc(db_presc_r);
      default:       err_s = 1'b1;
    endcase
  end

  // W1C mask for the interrupt status register
  always_comb begin
    if (wr_s && (PADDR[7:0] == ADDR_INT_STAT)) begin
      w1c_s = wdata_s;
    end else begin
      w1c_s = '0;
    end
  end

  assign rise_s     = filt_r & ~prev_r;
  assign fall_s     = ~filt_r & prev_r;
  assign edge_ev_s  = (int_both_r & (rise_s | fall_s)) |
                      (~int_both_r & ((int_pol_r & fall_s) | (~int_pol_r & rise_s)));
  assign level_ev_s = filt_r ^ int_pol_r;
  assign event_s    = (int_type_r & level_ev_s) | (~int_type_r & edge_ev_s);

  // Configuration and output registers written over APB
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      data_out_r <= '0;
      dir_r      <= '0;
      int_en_r   <= '0;
      int_type_r <= '0;
      int_pol_r  <= '0;
      int_both_r <= '0;
      db_en_r    <= '0;
      db_presc_r <= '0;
    end else if (wr_s) begin
      case (PADDR[7:0])
        ADDR_DATA_OUT: data_out_r <= wdata_s;
        ADDR_OUT_SET:  data_out_r <= data_out_r | wdata_s;
        ADDR_OUT_CLR:  data_out_r <= data_out_r & ~wdata_s;
        ADDR_DIR:      dir_r      <= wdata_s;
        ADDR_INT_EN:   int_en_r   <= wdata_s;
        ADDR_INT_TYPE: int_type_r <= wdata_s;
        ADDR_INT_POL:  int_pol_r  <= wdata_s;
        ADDR_INT_BOTH: int_both_r <= wdata_s;
        ADDR_DB_EN:    db_en_r    <= wdata_s;
        ADDR_DB_PRESC: db_presc_r <= PWDATA[PRESC_W-1:0];
        default:       ;
      endcase
    end
  end

  // APB response: read data holds between reads, error pulses for one cycle
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      prdata_r  <= 32'h0;
      pslverr_r <= 1'b0;
    end else begin
      pslverr_r <= access_s & err_s;
      if (rd_s) begin
        prdata_r <= rdata_s;
      end
    end
  end

  // Debounce prescaler; restarts whenever DB_PRESC is written
  always_ff @(posedge PCLK) begin
    if (PRESET || presc_wr_s || tick_s) begin
      presc_cnt_r <= '0;
    end else begin
      presc_cnt_r <= presc_cnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

  // Synchroniser, per-pin debounce filter, edge history and interrupt state
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync1_r    <= '0;
      sync2_r    <= '0;
      filt_r     <= '0;
      prev_r     <= '0;
      int_stat_r <= '0;
      irq_pin_r  <= '0;
      irq_r      <= 1'b0;
      for (int i = 0; i < NUM_PINS; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r    <= gpio_in;
      sync2_r    <= sync1_r;
      prev_r     <= filt_r;
      // a new event wins over a same-cycle W1C of that bit
      int_stat_r <= (int_stat_r & ~w1c_s) | event_s;
      irq_pin_r  <= int_stat_r & int_en_r;
      irq_r      <= |(int_stat_r & int_en_r);
      for (int i = 0; i < NUM_PINS; i++) begin
        if (!db_en_r[i]) begin
          filt_r[i]   <= sync2_r[i];
          db_cnt_r[i] <= '0;
        end else if (tick_s) begin
          // a sample equal to the accepted level restarts the count
          if (sync2_r[i] == filt_r[i]) begin
            db_cnt_r[i] <= '0;
          end else if (db_cnt_r[i] == CNT_W'(DB_SAMPLES - 1)) begin
            filt_r[i]   <= sync2_r[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign PRDATA   = prdata_r;
  assign PSLVERR  = pslverr_r;
  assign PREADY   = 1'b1;
  assign gpio_out = data_out_r;
  assign gpio_oe  = dir_r;
  assign irq_pin  = irq_pin_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_gpio_apb_bank.sv
// Directed bench for gpio_apb_bank: a 32-pin bank and an 8-pin bank share one APB bus
// and are selected by sel8.
module tb_gpio_apb_bank;

  logic        PCLK, PRESET, PSEL, PENABLE, PWRITE, sel8;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b, irq_a, irq_b;
  logic [31:0] gpio_in_a, gpio_out_a, gpio_oe_a, irq_pin_a;
  logic [7:0]  gpio_in_b, gpio_out_b, gpio_oe_b, irq_pin_b;
  logic        psel_a, psel_b;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;
  logic        er;

  assign psel_a = PSEL & ~sel8;
  assign psel_b = PSEL & sel8;

  gpio_apb_bank dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_a), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_a), .PREADY(pready_a),
    .PSLVERR(pslverr_a), .gpio_in(gpio_in_a), .gpio_out(gpio_out_a), .gpio_oe(gpio_oe_a),
    .irq_pin(irq_pin_a), .irq(irq_a)
  );

  gpio_apb_bank #(.NUM_PINS(8)) dut8 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_b), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_b), .PREADY(pready_b),
    .PSLVERR(pslverr_b), .gpio_in(gpio_in_b), .gpio_out(gpio_out_b), .gpio_oe(gpio_oe_b),
    .irq_pin(irq_pin_b), .irq(irq_b)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the access edge
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = {24'h0, a}; PWDATA = d;
    cyc(1);
    PENABLE = 1'b1;
    cyc(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    rdata = sel8 ? prdata_b : prdata_a;
    err   = sel8 ? pslverr_b : pslverr_a;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] x;
    logic e;
    xfer(1'b1, a, d, x, e);
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; sel8 = 1'b0;
    PADDR = 32'h0; PWDATA = 32'h0; gpio_in_a = 32'h0; gpio_in_b = 8'h0;
    cyc(3);
    PRESET = 1'b0;

    // 1. reset state and register map
    check("rst_gpio_out", gpio_out_a, 32'h0);
    check("rst_gpio_oe", gpio_oe_a, 32'h0);
    check("rst_irq", {31'h0, irq_a}, 32'h0);
    check("rst_irq_pin", irq_pin_a, 32'h0);
    check("pready", {31'h0, pready_a}, 32'h1);
    check("rst_pslverr", {31'h0, pslverr_a}, 32'h0);
    for (int off = 0; off <= 44; off += 4) begin
      xfer(1'b0, 8'(off), 32'h0, rd, er);
      check($sformatf("rst_read_%02h", off), rd, 32'h0);
    end
    xfer(1'b0, 8'h30, 32'h0, rd, er);
    check("unmapped_err", {31'h0, er}, 32'h1);
    check("unmapped_data", rd, 32'h0);
    cyc(1);
    check("err_one_cycle", {31'h0, pslverr_a}, 32'h0);
    xfer(1'b1, 8'h00, 32'hFFFF_FFFF, rd, er);
    check("wr_data_in_err", {31'h0, er}, 32'h1);

    // 2. output path
    wr(8'h10, 32'h0000_00FF);
    wr(8'h04, 32'h0000_000F);
    wr(8'h08, 32'h0000_00F0);
    wr(8'h0C, 32'h0000_0003);
    check("gpio_out", gpio_out_a, 32'h0000_00FC);
    check("gpio_oe", gpio_oe_a, 32'h0000_00FF);
    xfer(1'b0, 8'h04, 32'h0, rd, er);
    check("rd_data_out", rd, 32'h0000_00FC);
    xfer(1'b0, 8'h08, 32'h0, rd, er);
    check("rd_out_set", rd, 32'h0);
    xfer(1'b0, 8'h00, 32'h0, rd, er);
    check("no_loopback", rd, 32'h0);

    // 3. edge interrupts: pin0 rise, pin1 fall, pin2 both
    wr(8'h1C, 32'h0000_0002);
    wr(8'h20, 32'h0000_0004);
    wr(8'h14, 32'h0000_0007);
    gpio_in_a[0] = 1'b1;
    cyc(4);
    check("irq_cycle4", {31'h0, irq_a}, 32'h0);
    cyc(1);
    check("irq_cycle5", {31'h0, irq_a}, 32'h1);
    check("irq_pin0", irq_pin_a, 32'h1);
    gpio_in_a[0] = 1'b0; cyc(6);
    gpio_in_a[1] = 1'b1; cyc(6);
    xfer(1'b0, 8'h24, 32'h0, rd, er);
    check("fall_pin_no_rise_evt", rd, 32'h1);
    gpio_in_a[1] = 1'b0; cyc(6);
    gpio_in_a[2] = 1'b1; cyc(6);
    gpio_in_a[2] = 1'b0; cyc(6);
    xfer(1'b0, 8'h24, 32'h0, rd, er);
    check("int_stat_edges", rd, 32'h7);
    wr(8'h24, 32'h0000_0007);
    cyc(1);
    check("irq_after_w1c", {31'h0, irq_a}, 32'h0);
    xfer(1'b0, 8'h24, 32'h0, rd, er);
    check("int_stat_cleared", rd, 32'h0);

    // 4. level-high interrupt on pin3; W1C during an active level keeps the bit set
    wr(8'h18, 32'h0000_0008);
    wr(8'h14, 32'h0000_000F);
    gpio_in_a[3] = 1'b1;
    cyc(6);
    xfer(1'b0, 8'h24, 32'h0, rd, er);
    check("level_stat", rd, 32'h8);
    wr(8'h24, 32'h0000_0008);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check($sformatf("level_set_wins_%0d", k), irq_pin_a, 32'h8);
    end
    xfer(1'b0, 8'h24, 32'h0, rd, er);
    check("level_reset_after_w1c", rd, 32'h8);
    gpio_in_a[3] = 1'b0;
    cyc(5);
    wr(8'h24, 32'h0000_0008);
    cyc(2);
    xfer(1'b0, 8'h24, 32'h0, rd, er);
    check("level_released", rd, 32'h0);
    check("irq_released", {31'h0, irq_a}, 32'h0);

    // 5. debounce on pin4, tick every 10 cycles, 4 samples
    wr(8'h2C, 32'h0000_0009);
    wr(8'h28, 32'h0000_0010);
    xfer(1'b0, 8'h2C, 32'h0, rd, er);
    check("rd_db_presc", rd, 32'h9);
    gpio_in_a[4] = 1'b1; cyc(15);
    gpio_in_a[4] = 1'b0; cyc(30);
    xfer(1'b0, 8'h00, 32'h0, rd, er);
    check("glitch_rejected", rd, 32'h0);
    gpio_in_a[4] = 1'b1; cyc(25);
    xfer(1'b0, 8'h00, 32'h0, rd, er);
    check("db_not_yet", rd, 32'h0);
    cyc(25);
    xfer(1'b0, 8'h00, 32'h0, rd, er);
    check("db_accepted", rd, 32'h10);
    gpio_in_a[5] = 1'b1; cyc(3);
    xfer(1'b0, 8'h00, 32'h0, rd, er);
    check("no_db_pin5", rd, 32'h30);

    // 6. 8-pin build: unimplemented bits read 0
    sel8 = 1'b1;
    wr(8'h10, 32'hFFFF_FFFF);
    xfer(1'b0, 8'h10, 32'h0, rd, er);
    check("dir8_masked", rd, 32'h0000_00FF);
    check("gpio_oe8", {24'h0, gpio_oe_b}, 32'h0000_00FF);
    wr(8'h2C, 32'hFFFF_FFFF);
    xfer(1'b0, 8'h2C, 32'h0, rd, er);
    check("presc8_width", rd, 32'h0000_FFFF);
    sel8 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
